// File: rtl/sseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// sseg_scan_decoder
//
// Purpose:
//   Watches a multiplexed (scanned) 4-digit seven-segment display bus and
//   reconstructs the per-digit segment patterns. Each {an,sseg} sample is
//   registered, debounced by requiring STABLE_CYCLES identical samples, and
//   then latched into the digit selected by the single low enable bit. The
//   latched patterns are decoded back to hex values. Frame tracking reports
//   when all four digits have been captured. A no-activity watchdog flags a
//   dead bus.
//
// Ports:
//   clk            rising-edge system clock
//   reset          synchronous, active-high reset
//   an[3:0]        scanned digit enables, active-low
//   sseg[7:0]      scanned segment bus {dp,g,f,e,d,c,b,a}, active-low
//   dig3..dig0     last accepted raw pattern per digit, active-low
//   hex3..hex0     decoded hex value per digit (0 when not a glyph)
//   hex_ok[3:0]    bit i = dig_i matched a hex glyph
//   dp[3:0]        bit i = decimal point lit on digit i (active-high)
//   frame_valid    a complete 4-digit frame captured since reset/timeout
//   frame_strobe   one-cycle pulse when a frame completes
//   scan_err       one-cycle pulse on a stable illegal enable pattern
//   timeout        level; no digit accepted for 2^TIMEOUT_BITS-1 cycles
//
// Handshake: there is no handshake; the input bus is free-running and every
// rising edge captures one sample.
// -----------------------------------------------------------------------------
module sseg_scan_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_BITS  = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] an,
   input  logic [7:0] sseg,
   output logic [7:0] dig3,
   output logic [7:0] dig2,
   output logic [7:0] dig1,
   output logic [7:0] dig0,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0,
   output logic [3:0] hex_ok,
   output logic [3:0] dp,
   output logic       frame_valid,
   output logic       frame_strobe,
   output logic       scan_err,
   output logic       timeout
);

   localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);
   localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [TIMEOUT_BITS-1:0] WD_MAX  = '1;
   localparam logic [TIMEOUT_BITS-1:0] WD_NEAR = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
   localparam logic [TIMEOUT_BITS-1:0] WD_ONE  = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

   // Sample register and the sample before it; the run counter compares
   // these two so every decision is taken from registered values.
   logic [3:0]              r_an;
   logic [7:0]              r_sseg;
   logic [3:0]              r_prev_an;
   logic [7:0]              r_prev_sseg;
   logic [7:0]              r_run;
   logic [TIMEOUT_BITS-1:0] r_wd;
   logic [3:0]              r_seen;
   logic [7:0]              r_dig [0:3];
   logic                    r_frame_valid;
   logic                    r_frame_strobe;
   logic                    r_scan_err;

   logic       w_match;
   logic       w_stable_evt;
   logic [3:0] w_low;
   logic       w_one_low;
   logic       w_accept;
   logic       w_multi;
   logic [3:0] w_seen_next;
   logic       w_wd_sat_next;

   assign w_match = ({r_an, r_sseg} == {r_prev_an, r_prev_sseg});

   // The event fires on the single edge where the run counter steps from
   // STABLE_CYCLES-1 to STABLE_CYCLES; saturation prevents repeats.
   assign w_stable_evt = w_match && (r_run == RUN_LAST);

   assign w_low     = ~r_an;
   assign w_one_low = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
   assign w_accept  = w_stable_evt && w_one_low;
   assign w_multi   = w_stable_evt && (w_low != 4'd0) && !w_one_low;

   assign w_seen_next = r_seen | w_low;

   // True on the edge where the watchdog becomes (or already is) all-ones.
   assign w_wd_sat_next = (r_wd == WD_NEAR) || (r_wd == WD_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_an           <= 4'hF;
         r_sseg         <= 8'hFF;
         r_prev_an      <= 4'hF;
         r_prev_sseg    <= 8'hFF;
         r_run          <= 8'd0;
         r_wd           <= '0;
         r_seen         <= 4'd0;
         r_frame_valid  <= 1'b0;
         r_frame_strobe <= 1'b0;
         r_scan_err     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_dig[i] <= 8'hFF;
         end
      end else begin
         r_an        <= an;
         r_sseg      <= sseg;
         r_prev_an   <= r_an;
         r_prev_sseg <= r_sseg;

         if (!w_match) begin
            r_run <= 8'd1;
         end else if (r_run != RUN_MAX) begin
            r_run <= r_run + 8'd1;
         end

         r_frame_strobe <= 1'b0;
         r_scan_err     <= w_multi;

         if (w_accept) begin
            for (int i = 0; i < 4; i++) begin
               if (w_low[i]) begin
                  r_dig[i] <= r_sseg;
               end
            end
            r_wd <= '0;
            // Completing the set restarts tracking for the next frame.
            if (w_seen_next == 4'hF) begin
               r_seen         <= 4'd0;
               r_frame_valid  <= 1'b1;
               r_frame_strobe <= 1'b1;
            end else begin
               r_seen <= w_seen_next;
            end
         end else begin
            if (r_wd != WD_MAX) begin
               r_wd <= r_wd + WD_ONE;
            end
            if (w_wd_sat_next) begin
               r_seen        <= 4'd0;
               r_frame_valid <= 1'b0;
            end
         end
      end
   end

   // Returns {ok, value}; unknown patterns decode to {0, 0}.
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] v;
      case (seg)
         7'h40:   v = 5'h10;
         7'h79:   v = 5'h11;
         7'h24:   v = 5'h12;
         7'h30:   v = 5'h13;
         7'h19:   v = 5'h14;
         7'h12:   v = 5'h15;
         7'h02:   v = 5'h16;
         7'h78:   v = 5'h17;
         7'h00:   v = 5'h18;
         7'h10:   v = 5'h19;
         7'h08:   v = 5'h1A;
         7'h03:   v = 5'h1B;
         7'h46:   v = 5'h1C;
         7'h21:   v = 5'h1D;
         7'h06:   v = 5'h1E;
         7'h0E:   v = 5'h1F;
         default: v = 5'h00;
      endcase
      return v;
   endfunction

   assign dig0 = r_dig[0];
   assign dig1 = r_dig[1];
   assign dig2 = r_dig[2];
   assign dig3 = r_dig[3];

   assign {hex_ok[0], hex0} = f_decode(r_dig[0][6:0]);
   assign {hex_ok[1], hex1} = f_decode(r_dig[1][6:0]);
   assign {hex_ok[2], hex2} = f_decode(r_dig[2][6:0]);
   assign {hex_ok[3], hex3} = f_decode(r_dig[3][6:0]);

   assign dp = ~{r_dig[3][7], r_dig[2][7], r_dig[1][7], r_dig[0][7]};

   assign frame_valid  = r_frame_valid;
   assign frame_strobe = r_frame_strobe;
   assign scan_err     = r_scan_err;
   assign timeout      = (r_wd == WD_MAX);

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 The block SHALL have parameter TIMEOUT_BITS, default 20: width of the no-activity watchdog counter.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, and SHALL have these ports:
- clk  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high reset
- an  in  4  scanned digit enables, active-low
- sseg  in  8  scanned segment bus {dp,g,f,e,d,c,b,a}, active-low
- dig3, dig2, dig1, dig0  out  8 each  last accepted raw pattern per digit, active-low
- hex3, hex2, hex1, hex0  out  4 each  decoded hex value per digit
- hex_ok  out  4  bit i = dig_i matched a hex glyph
- dp  out  4  bit i = decimal point lit on digit i (active-high)
- frame_valid  out  1  a complete 4-digit frame has been captured since reset or timeout
- frame_strobe  out  1  one-cycle pulse when a frame completes
- scan_err  out  1  one-cycle pulse on a stable illegal enable pattern
- timeout  out  1  level; no digit has been accepted for 2^TIMEOUT_BITS-1 cycles

Function
REQ-004 The block SHALL register {an,sseg} into a sample register on every rising edge; all decisions SHALL use registered values only.
REQ-005 The block SHALL maintain a run counter that resets to 1 when the new sample differs from the previous sample, increments when it matches, and saturates at STABLE_CYCLES.
REQ-006 A "stable event" SHALL occur exactly once per run: on the edge at which the run counter reaches STABLE_CYCLES. A run that keeps its value for longer SHALL NOT produce further events.
REQ-007 If a stable event occurs with exactly one an bit low (bit i), the block SHALL latch the sampled sseg into dig_i on that edge, set seen[i], and clear the watchdog counter.
REQ-008 Port-to-output latency SHALL be STABLE_CYCLES+1 rising edges from the first edge that samples a new constant port value.
REQ-009 A stable event with an=1111 (blanking) SHALL take no action.
REQ-010 A stable event with two or more an bits low SHALL pulse scan_err for one cycle and SHALL change no dig, seen, or watchdog state.
REQ-011 hex_i/hex_ok_i SHALL be decoded combinationally from dig_i[6:0] using these glyphs: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex). Any other pattern SHALL give hex_i=0 and hex_ok_i=0.
REQ-012 dp[i] SHALL equal ~dig_i[7].
REQ-013 When seen would become 1111 on an edge, the block SHALL instead clear seen to 0000 on that edge, set frame_valid, and assert frame_strobe during the following cycle only.
REQ-014 A repeated acceptance of an already-seen digit SHALL update dig_i and SHALL NOT advance frame completion.
REQ-015 The watchdog SHALL increment every cycle without an acceptance and saturate at all-ones.
REQ-016 At watchdog saturation the block SHALL assert timeout, clear frame_valid, and clear seen; timeout SHALL deassert on the edge of the next acceptance.
REQ-017 Scan order SHALL be irrelevant; frames complete on any order of the four digits.

Reset
REQ-018 While reset is high at a rising edge, the block SHALL set:
- sample register to an=1111, sseg=FF
- run counter, watchdog, and seen to 0
- dig0..dig3 to FF
- frame_valid, frame_strobe, scan_err, and timeout to 0
REQ-019 hex, hex_ok, and dp SHALL follow from the reset dig values: hex=0, hex_ok=0, dp=0.
REQ-020 Assertion of reset mid-run or mid-frame SHALL discard the partial run and frame; no stable event SHALL occur before STABLE_CYCLES samples after reset release.

Verification (STABLE_CYCLES=4, TIMEOUT_BITS=8)
REQ-021 Drive an=1110, sseg=C0 constant from reset release -> dig0=C0, hex0=0, hex_ok[0]=1, dp[0]=0 exactly 5 edges later; no further updates while the value is held.
REQ-022 Scan the four digits with values 79, 24, 30, 19 (dp off), holding each for 8 cycles -> hex3..0=4,3,2,1; one frame_strobe pulse; frame_valid=1.
REQ-023 Glitch: hold an=1101, sseg=24 for 3 cycles, then change -> dig1 stays FF; no frame progress.
REQ-024 Hold an=1100 for 6 cycles -> exactly one scan_err pulse; dig0 and dig1 unchanged.
REQ-025 After a valid frame, hold an=1111 for 260 cycles -> timeout=1 and frame_valid=0; then one valid digit is accepted -> timeout=0.
REQ-026 Assert reset after 3 digits have been accepted, then scan the remaining digit only -> no frame_strobe; all dig outputs = FF except the newly accepted digit.
